// File: rtl/i2c_slave_pkg.sv
// Shared state encoding and bus constants for the I2C slave register file.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_e;

  localparam logic       ACK                = 1'b0;
  localparam logic       NACK               = 1'b1;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Register-write notification and bus-activity signals of the I2C slave.
interface i2c_slave_regfile_if;
  logic       busy_o;
  logic       wr_strobe_o;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;

  modport slave  (output busy_o, output wr_strobe_o, output wr_addr_o, output wr_data_o);
  modport master (input  busy_o, input  wr_strobe_o, input  wr_addr_o, input  wr_data_o);
endinterface

// File: rtl/i2c_slave_sync_filter.sv
// Two-flop synchronizer plus edge detect for one I2C line.
// Optional run-length glitch filter when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave_sync_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q, level;

  if (FILT_LEN < 1) begin : g_bad_len
    $error("FILT_LEN must be at least 1");
  end

  // Idle I2C lines are high, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] run_q, run_d;

  // Output follows the input only after FILT_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == CNT_W'(FILT_LEN - 1)) filt_d = sync2_q;
      else                               run_d  = run_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign level_o = level;
  assign rise_o  = level & ~prev_q;
  assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave serving pointer-addressed byte register reads/writes with auto-increment.
// Build option: define I2C_SLAVE_GLITCH_FILTER_EN to filter SCL/SDA glitches.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         DEPTH      = 16,
  parameter int         FILT_LEN   = 3
) (
  input  logic               i2c_core_clock_i,
  input  logic               i2c_core_reset_n_i,
  input  logic               scl_io,
  inout  wire                sda_io,
  i2c_slave_regfile_if.slave wr_if
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 in 2..256");
  end

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_slave_sync_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(i2c_core_clock_i), .rst_n(i2c_core_reset_n_i), .line_i(scl_io),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_slave_sync_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(i2c_core_clock_i), .rst_n(i2c_core_reset_n_i), .line_i(sda_io),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             rw_q, rw_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       regs_q [DEPTH];
  logic [7:0]       rx_byte;
  logic             reg_we;

  assign rx_byte = {shift_q[6:0], sda_lvl};
  assign ptr_inc = ptr_q + PTR_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
    // Bus conditions win over any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                rw_d    = rx_byte[0];
                state_d = (rx_byte[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = 8'(ptr_q);
                wr_data_d   = rx_byte;
                ptr_d       = ptr_inc;
                state_d     = ST_WDATA_ACK;
              end
            end
          end
        end
        // cnt_q doubles as ACK phase: 0 = waiting to drive ACK, 1 = ACK on the bus.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b1;
              cnt_d    = 3'd1;
            end else begin
              cnt_d    = '0;
              sda_oe_d = 1'b0;
              state_d  = ST_WDATA;
              if (state_q == ST_ADDR_ACK) begin
                if (rw_q) begin
                  shift_d  = regs_q[ptr_q];
                  sda_oe_d = ~regs_q[ptr_q][7];
                  state_d  = ST_RDATA;
                end else begin
                  state_d  = ST_PTR;
                end
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = ST_RDATA_ACK;
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end
        end
        ST_RDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (sda_lvl == NACK) begin
              state_d = ST_IGNORE;
            end else begin
              ptr_d   = ptr_inc;
              shift_d = regs_q[ptr_inc];
              cnt_d   = '0;
              state_d = ST_RDATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i2c_core_clock_i or negedge i2c_core_reset_n_i) begin
    if (!i2c_core_reset_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge i2c_core_clock_i or negedge i2c_core_reset_n_i) begin
    if (!i2c_core_reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  assign sda_io            = sda_oe_q ? ACK : 1'bz;
  assign wr_if.busy_o      = busy_q;
  assign wr_if.wr_strobe_o = wr_strobe_q;
  assign wr_if.wr_addr_o   = wr_addr_q;
  assign wr_if.wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: table-driven write bursts, scoreboarded
// write strobes, read-back with repeated START, reset mid-read and an SDA glitch.
module tb_i2c_slave_regfile;
  import i2c_slave_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_regfile_if wr_if();

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .DEPTH(16), .FILT_LEN(3)) dut (
    .i2c_core_clock_i   (clk),
    .i2c_core_reset_n_i (rst_n),
    .scl_io             (scl),
    .sda_io             (sda_bus),
    .wr_if              (wr_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cycles = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } wvec_t;

  wr_t        sb_q[$];
  wr_t        exp_w;
  logic [7:0] model [16];
  wvec_t      vecs [5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_if.busy_o) busy_cycles++;
    if (rst_n && wr_if.wr_strobe_o) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL strobe: got write addr %02h data %02h, required no write",
                 wr_if.wr_addr_o, wr_if.wr_data_o);
      end else begin
        exp_w = sb_q.pop_front();
        check("strobe addr/data", {wr_if.wr_addr_o, wr_if.wr_data_o}, {exp_w.addr, exp_w.data});
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; master drives b (1 = release) and samples the bus mid-high.
  task automatic bit_xfer(input logic b, output logic s);
    clks(2);
    m_sda_low = ~b;
    clks(8);
    scl = 1'b1;
    clks(5);
    s = sda_bus;
    clks(5);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      clks(2);
      m_sda_low = 1'b0;
      clks(8);
      scl = 1'b1;
      clks(5);
    end
    m_sda_low = 1'b1;
    clks(8);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(2);
    m_sda_low = 1'b1;
    clks(8);
    scl = 1'b1;
    clks(5);
    m_sda_low = 1'b0;
    clks(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(m_ack, s);
  endtask

  task automatic do_read(input logic [3:0] p, input int n);
    logic       a;
    logic [7:0] d;
    logic [3:0] idx;
    i2c_start();
    send_byte(8'hA0, a);
    check("rd dev-w ack", 16'(a), 16'(ACK));
    send_byte({4'h0, p}, a);
    check("rd ptr ack", 16'(a), 16'(ACK));
    i2c_start();
    send_byte(8'hA1, a);
    check("rd dev-r ack", 16'(a), 16'(ACK));
    for (int k = 0; k < n; k++) begin
      idx = p + 4'(k);
      recv_byte((k == n - 1) ? NACK : ACK, d);
      check($sformatf("rd data reg[%0d]", idx), 16'(d), 16'(model[idx]));
    end
    clks(4);
    check("sda released after nack", 16'(sda_bus), 16'd1);
    i2c_stop();
    check("busy after read stop", 16'(wr_if.busy_o), 16'd0);
    $display("read  ptr %02h bytes %0d done", p, n);
  endtask

  initial begin
    logic       a;
    logic [3:0] p;
    logic [7:0] d;

    vecs[0] = '{dev: 8'hA0, ptr: 8'h03, n: 2, d0: 8'h11, d1: 8'h22, exp_ack: 1'b1};
    vecs[1] = '{dev: 8'hB0, ptr: 8'h55, n: 0, d0: 8'h00, d1: 8'h00, exp_ack: 1'b0};
    vecs[2] = '{dev: 8'hA0, ptr: 8'h0F, n: 2, d0: 8'hAA, d1: 8'hBB, exp_ack: 1'b1};
    vecs[3] = '{dev: 8'hA2, ptr: 8'h07, n: 1, d0: 8'h5A, d1: 8'h00, exp_ack: 1'b0};
    vecs[4] = '{dev: 8'hA0, ptr: 8'h07, n: 1, d0: 8'h5A, d1: 8'h00, exp_ack: 1'b1};
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    clks(3);
    check("reset busy", 16'(wr_if.busy_o), 16'd0);
    check("reset strobe", 16'(wr_if.wr_strobe_o), 16'd0);
    check("reset wr_addr", 16'(wr_if.wr_addr_o), 16'd0);
    check("reset wr_data", 16'(wr_if.wr_data_o), 16'd0);
    check("reset sda", 16'(sda_bus), 16'd1);
    rst_n = 1'b1;
    clks(10);

    // One-clock SDA low pulse with SCL high.
    busy_cycles = 0;
    m_sda_low = 1'b1;
    clks(1);
    m_sda_low = 1'b0;
    clks(20);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    check("glitch busy cycles", 16'(busy_cycles), 16'd0);
`else
    check("glitch busy cycles", 16'(busy_cycles), 16'd1);
`endif
    check("busy after glitch", 16'(wr_if.busy_o), 16'd0);
    $display("glitch pulse busy cycles %0d", busy_cycles);

    for (int v = 0; v < 5; v++) begin
      i2c_start();
      check($sformatf("vec%0d busy after start", v), 16'(wr_if.busy_o), 16'd1);
      send_byte(vecs[v].dev, a);
      check($sformatf("vec%0d dev ack", v), 16'(a), 16'(vecs[v].exp_ack ? ACK : NACK));
      send_byte(vecs[v].ptr, a);
      check($sformatf("vec%0d ptr ack", v), 16'(a), 16'(vecs[v].exp_ack ? ACK : NACK));
      p = vecs[v].ptr[3:0];
      for (int k = 0; k < vecs[v].n; k++) begin
        d = (k == 0) ? vecs[v].d0 : vecs[v].d1;
        if (vecs[v].exp_ack) begin
          sb_q.push_back('{addr: {4'h0, p}, data: d});
          model[p] = d;
          p = p + 4'd1;
        end
        send_byte(d, a);
        check($sformatf("vec%0d data%0d ack", v, k), 16'(a),
              16'(vecs[v].exp_ack ? ACK : NACK));
      end
      i2c_stop();
      check($sformatf("vec%0d busy after stop", v), 16'(wr_if.busy_o), 16'd0);
      check($sformatf("vec%0d strobes outstanding", v), 16'(sb_q.size()), 16'd0);
      $display("write vec %0d dev %02h ptr %02h bytes %0d", v, vecs[v].dev, vecs[v].ptr, vecs[v].n);
    end

    do_read(4'h3, 2);
    do_read(4'hF, 2);
    do_read(4'h7, 1);
    do_read(4'h0, 16);

    // Reset while the slave drives the MSB (0) of reg[3] = 0x11.
    i2c_start();
    send_byte(8'hA0, a);
    check("rst dev-w ack", 16'(a), 16'(ACK));
    send_byte(8'h03, a);
    check("rst ptr ack", 16'(a), 16'(ACK));
    i2c_start();
    send_byte(8'hA1, a);
    check("rst dev-r ack", 16'(a), 16'(ACK));
    clks(8);
    check("slave drives msb low", 16'(sda_bus), 16'd0);
    rst_n = 1'b0;
    #1;
    check("sda released in reset", 16'(sda_bus), 16'd1);
    check("busy in reset", 16'(wr_if.busy_o), 16'd0);
    @(negedge clk);
    scl = 1'b1;
    m_sda_low = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(5);
    check("post-reset wr_addr", 16'(wr_if.wr_addr_o), 16'd0);
    check("post-reset wr_data", 16'(wr_if.wr_data_o), 16'd0);
    $display("reset mid-read applied");
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    do_read(4'h0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
